// File: rtl/register_xfer_seq.sv
// Parametrised transfer register: full-word load/drive on the transfer and address buses,
// byte-at-a-time load/drive on the main bus through a wrapping byte pointer, and in-place inc/dec.
module register_xfer_seq #(
   parameter int WIDTH_MAIN = 8,
   parameter int BYTES      = 2,
   parameter int BIG_ENDIAN = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [WIDTH_MAIN*BYTES-1:0]   xfer_in,
   input  logic                          load_xfer,
   input  logic                          assert_xfer,
   output logic [WIDTH_MAIN*BYTES-1:0]   xfer_out,
   output logic                          xfer_en,
   input  logic                          assert_addr,
   output logic [WIDTH_MAIN*BYTES-1:0]   addr_out,
   output logic                          addr_en,
   input  logic [WIDTH_MAIN-1:0]         main_in,
   input  logic                          load_main,
   input  logic                          assert_main,
   output logic [WIDTH_MAIN-1:0]         main_out,
   output logic                          main_en,
   input  logic                          ptr_clr,
   input  logic                          inc,
   input  logic                          dec,
   output logic [$clog2(BYTES)-1:0]      ptr_out,
   output logic                          seq_last
);

   localparam int WIDTH_AX = WIDTH_MAIN * BYTES;
   localparam int PTR_W    = $clog2(BYTES);
   localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(BYTES - 1);
   localparam logic [WIDTH_AX-1:0] WORD_ONE = WIDTH_AX'(1);

   logic [WIDTH_AX-1:0]   word;
   logic [WIDTH_AX-1:0]   word_next;
   logic [PTR_W-1:0]      ptr;
   logic [PTR_W-1:0]      ptr_next;
   logic [PTR_W-1:0]      ptr_adv;
   logic [PTR_W-1:0]      byte_idx;
   logic [WIDTH_MAIN-1:0] main_sel;
   logic                  last;

   assign last    = (ptr == PTR_LAST);
   assign ptr_adv = last ? {PTR_W{1'b0}} : (ptr + PTR_ONE);

   // Map the sequence pointer onto a physical byte lane according to byte order.
   always_comb begin
      byte_idx = ptr;
      if (BIG_ENDIAN != 0) begin
         byte_idx = PTR_LAST - ptr;
      end else begin
         byte_idx = ptr;
      end
   end

   // Select the byte lane currently addressed by the pointer.
   always_comb begin
      main_sel = {WIDTH_MAIN{1'b0}};
      for (int k = 0; k < BYTES; k++) begin
         main_sel = main_sel | ((byte_idx == PTR_W'(k)) ? word[k*WIDTH_MAIN +: WIDTH_MAIN]
                                                       : {WIDTH_MAIN{1'b0}});
      end
   end

   // Next word: full load beats byte write beats count; inc and dec together cancel.
   always_comb begin
      word_next = word;
      if (!load_xfer) begin
         word_next = xfer_in;
      end else if (!load_main) begin
         for (int k = 0; k < BYTES; k++) begin
            word_next[k*WIDTH_MAIN +: WIDTH_MAIN] = (byte_idx == PTR_W'(k)) ? main_in
                                                   : word[k*WIDTH_MAIN +: WIDTH_MAIN];
         end
      end else if (!inc && dec) begin
         word_next = word + WORD_ONE;
      end else if (inc && !dec) begin
         word_next = word - WORD_ONE;
      end else begin
         word_next = word;
      end
   end

   // Next pointer: a clear or a full load restarts the sequence; any main-bus byte access advances once.
   always_comb begin
      ptr_next = ptr;
      if (!ptr_clr || !load_xfer) begin
         ptr_next = {PTR_W{1'b0}};
      end else if (!load_main || !assert_main) begin
         ptr_next = ptr_adv;
      end else begin
         ptr_next = ptr;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         word <= {WIDTH_AX{1'b0}};
         ptr  <= {PTR_W{1'b0}};
      end else begin
         word <= word_next;
         ptr  <= ptr_next;
      end
   end

   assign xfer_en  = ~assert_xfer;
   assign addr_en  = ~assert_addr;
   assign main_en  = ~assert_main;
   assign xfer_out = xfer_en ? word : {WIDTH_AX{1'b0}};
   assign addr_out = addr_en ? word : {WIDTH_AX{1'b0}};
   assign main_out = main_en ? main_sel : {WIDTH_MAIN{1'b0}};
   assign ptr_out  = ptr;
   assign seq_last = last;

endmodule
